// File: rtl/quad_sched_pkg.sv
// Shared types for the quadrature scheduler: FSM state encoding and the
// record payload presented on the rec_* interface.
// Optional feature macro: QUAD_SCHED_TIMESTAMP_EN adds a timestamp field.
package quad_sched_pkg;

  localparam int unsigned REC_CHAN_MAX_W  = 8;
  localparam int unsigned REC_DELTA_MAX_W = 64;
  localparam int unsigned REC_TS_W        = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_TICK,
    CAPTURE,
    EMIT
  } state_e;

  // Record payload; fields sized for the largest supported configuration and
  // narrowed to the instance widths at the top-level ports.
  typedef struct packed {
    logic [REC_CHAN_MAX_W-1:0]  chan;
    logic [REC_DELTA_MAX_W-1:0] delta;
    logic                       err;
`ifdef QUAD_SCHED_TIMESTAMP_EN
    logic [REC_TS_W-1:0]        timestamp;
`endif
  } rec_t;

endpackage

// File: rtl/quad_sched_timer.sv
// Sample-period timer for the quadrature scheduler.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   run        : count while high; count is held at 0 while low
//   tick       : registered, high while the count equals PERIOD-1
module quad_sched_timer #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; tick is derived from the next count so it lines up with cnt_q.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/quadrature_scheduler.sv
// Quadrature scheduler: every PERIOD cycles snapshots all decoder counts and
// emits one record per channel carrying the displacement change and the
// sticky error since that channel's previous record.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   enable              : run sampling (re-enable re-runs INIT)
//   displacement        : per-channel counts, channel i at [i*W +: W]
//   hw_err              : per-channel decoder error
//   clear_displacement  : decoder clear, all ones during INIT only
//   rec_valid/rec_ready : record handshake
//   rec_chan/rec_delta/rec_err : record fields
//   overrun             : sticky, a tick arrived mid-sweep and was dropped
//   rec_timestamp       : capture-cycle counter value (QUAD_SCHED_TIMESTAMP_EN)
// Optional feature macro: QUAD_SCHED_TIMESTAMP_EN.
module quadrature_scheduler
  import quad_sched_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned PERIOD        = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] displacement,
  input  logic [NUM_CH-1:0]               hw_err,
  output logic [NUM_CH-1:0]               clear_displacement,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [$clog2(NUM_CH)-1:0]       rec_chan,
  output logic [COUNTER_WIDTH-1:0]        rec_delta,
  output logic                            rec_err,
  output logic                            overrun
`ifdef QUAD_SCHED_TIMESTAMP_EN
  ,
  output logic [REC_TS_W-1:0]             rec_timestamp
`endif
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] snap_q [NUM_CH];
  logic [COUNTER_WIDTH-1:0] snap_d [NUM_CH];
  logic [COUNTER_WIDTH-1:0] last_q [NUM_CH];
  logic [COUNTER_WIDTH-1:0] last_d [NUM_CH];
  logic [NUM_CH-1:0]        err_q, err_d;
  logic                     ovr_q, ovr_d;
  logic                     stop_q, stop_d;
  logic [NUM_CH-1:0]        clear_q, clear_d;
  logic                     valid_q, valid_d;
  rec_t                     rec_q, rec_d;
  logic                     tick;
  logic                     run;
  logic                     xfer;
  logic                     stall;

`ifdef QUAD_SCHED_TIMESTAMP_EN
  logic [REC_TS_W-1:0]      cyc_q, cyc_d;
`endif

  assign run   = (state_q == WAIT_TICK) || (state_q == CAPTURE) || (state_q == EMIT);
  assign xfer  = valid_q & rec_ready;
  assign stall = valid_q & ~rec_ready;

  quad_sched_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    stop_d  = stop_q;

    // Clear only what the accepted record reported; new errors always set.
    for (int i = 0; i < NUM_CH; i++) begin
      err_d[i] = hw_err[i] |
                 (err_q[i] & ~(xfer & (idx_q == CW'(i)) & rec_q.err));
    end

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (enable) state_d = INIT;
      end
      INIT: begin
        stop_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) last_d[i] = '0;
        state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)   state_d = IDLE;
        else if (tick) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (tick)    ovr_d  = 1'b1;
        if (!enable) stop_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          snap_d[i] = displacement[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        end
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (tick)    ovr_d  = 1'b1;
        if (!enable) stop_d = 1'b1;
        if (xfer) begin
          last_d[idx_q] = snap_q[idx_q];
          if (idx_q == LAST_CH) begin
            state_d = (stop_q || !enable) ? IDLE : WAIT_TICK;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    clear_d = (state_d == INIT) ? '1 : '0;
    valid_d = (state_d == EMIT);

    rec_d = '0;
    if (state_d == EMIT) begin
      rec_d.chan  = REC_CHAN_MAX_W'(idx_d);
      rec_d.delta = REC_DELTA_MAX_W'(snap_d[idx_d] - last_d[idx_d]);
      // Hold the error flag while stalled so the presented record is stable.
      rec_d.err   = stall ? rec_q.err : err_d[idx_d];
`ifdef QUAD_SCHED_TIMESTAMP_EN
      rec_d.timestamp = (state_q == CAPTURE) ? cyc_q : rec_q.timestamp;
`endif
    end

`ifdef QUAD_SCHED_TIMESTAMP_EN
    cyc_d = cyc_q + REC_TS_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
        last_q[i] <= '0;
      end
      err_q   <= '0;
      ovr_q   <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= '0;
      valid_q <= 1'b0;
      rec_q   <= '0;
`ifdef QUAD_SCHED_TIMESTAMP_EN
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      stop_q  <= stop_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      rec_q   <= rec_d;
`ifdef QUAD_SCHED_TIMESTAMP_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign clear_displacement = clear_q;
  assign rec_valid          = valid_q;
  assign rec_chan           = CW'(rec_q.chan);
  assign rec_delta          = COUNTER_WIDTH'(rec_q.delta);
  assign rec_err            = rec_q.err;
  assign overrun            = ovr_q;
`ifdef QUAD_SCHED_TIMESTAMP_EN
  assign rec_timestamp      = rec_q.timestamp;
`endif

endmodule

// File: tb/tb_quadrature_scheduler.sv
// Directed self-checking bench for quadrature_scheduler (NUM_CH=4, W=32, PERIOD=20).
module tb_quadrature_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned PER = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NCH*W-1:0] displacement;
  logic [NCH-1:0]   hw_err;
  logic [NCH-1:0]   clear_displacement;
  logic             rec_valid;
  logic             rec_ready;
  logic [1:0]       rec_chan;
  logic [W-1:0]     rec_delta;
  logic             rec_err;
  logic             overrun;
`ifdef QUAD_SCHED_TIMESTAMP_EN
  logic [31:0]      rec_timestamp;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quadrature_scheduler #(
    .NUM_CH        (NCH),
    .COUNTER_WIDTH (W),
    .PERIOD        (PER)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .displacement       (displacement),
    .hw_err             (hw_err),
    .clear_displacement (clear_displacement),
    .rec_valid          (rec_valid),
    .rec_ready          (rec_ready),
    .rec_chan           (rec_chan),
    .rec_delta          (rec_delta),
    .rec_err            (rec_err),
    .overrun            (overrun)
`ifdef QUAD_SCHED_TIMESTAMP_EN
    ,
    .rec_timestamp      (rec_timestamp)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_disp(input int ch, input logic [W-1:0] v);
    displacement[ch*W +: W] = v;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rec_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_wait_valid"}, 64'(rec_valid), 64'd1);
  endtask

  // One full sweep with rec_ready=1; d packs expected deltas {ch3,ch2,ch1,ch0}.
  task automatic sweep(input string tag, input logic [NCH*W-1:0] d, input logic [NCH-1:0] e,
                       input int err_chan, input int drop_chan);
    wait_valid(tag);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 64'(rec_valid), 64'd1);
      check($sformatf("%s_chan%0d", tag, k), 64'(rec_chan), 64'(k));
      check($sformatf("%s_delta%0d", tag, k), 64'(rec_delta), 64'(d[k*W +: W]));
      check($sformatf("%s_err%0d", tag, k), 64'(rec_err), 64'(e[k]));
      if (k == err_chan)  hw_err[k] = 1'b1;
      if (k == drop_chan) enable = 1'b0;
      step();
      hw_err = '0;
    end
    check({tag, "_end_valid"}, 64'(rec_valid), 64'd0);
  endtask

  initial begin
    int n;
    int seen;

    rst_n        = 1'b0;
    enable       = 1'b0;
    rec_ready    = 1'b1;
    hw_err       = '0;
    displacement = '0;
    repeat (3) step();

    check("rst_valid", 64'(rec_valid), 64'd0);
    check("rst_clear", 64'(clear_displacement), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_chan", 64'(rec_chan), 64'd0);
    check("rst_delta", 64'(rec_delta), 64'd0);
    check("rst_err", 64'(rec_err), 64'd0);

    // Enable: one INIT cycle of clear, then tick 20 cycles later, record 2 after.
    set_disp(0, 32'h7);
    set_disp(3, 32'h10);
    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    check("init_clear", 64'(clear_displacement), 64'hF);
    step();
    check("post_init_clear", 64'(clear_displacement), 64'h0);
    n = 0;
    while (rec_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("first_latency", 64'(n), 64'd21);

    sweep("s1", {32'h10, 32'h0, 32'h0, 32'h7}, 4'b0000, -1, -1);
    check("s1_overrun", 64'(overrun), 64'd0);

    set_disp(2, 32'h5);
    sweep("s2", {32'h0, 32'h5, 32'h0, 32'h0}, 4'b0000, -1, -1);

    set_disp(2, 32'h3);
    set_disp(0, 32'hFFFF_FFFD);
    sweep("s3", {32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFF6}, 4'b0000, -1, -1);

    // Wrap-around: 0x00000002 - 0xFFFFFFFD = 5.
    set_disp(0, 32'h2);
    sweep("s4", {32'h0, 32'h0, 32'h0, 32'h5}, 4'b0000, -1, -1);

    // Single-cycle error pulse on channel 1.
    hw_err = 4'b0010;
    step();
    hw_err = '0;
    sweep("s5", '0, 4'b0010, -1, -1);
    // Error raised during channel 1's transfer cycle survives the clear.
    sweep("s6", '0, 4'b0000, 1, -1);
    sweep("s7", '0, 4'b0010, -1, -1);
    check("s7_overrun", 64'(overrun), 64'd0);

    // Back-pressure for 30 cycles spanning a tick.
    set_disp(3, 32'h20);
    set_disp(0, 32'h9);
    wait_valid("s8");
    rec_ready = 1'b0;
    set_disp(0, 32'd100);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("stall_valid%0d", i), 64'(rec_valid), 64'd1);
      check($sformatf("stall_chan%0d", i), 64'(rec_chan), 64'd0);
      check($sformatf("stall_delta%0d", i), 64'(rec_delta), 64'd7);
      check($sformatf("stall_err%0d", i), 64'(rec_err), 64'd0);
      step();
    end
    check("stall_overrun", 64'(overrun), 64'd1);
    rec_ready = 1'b1;
    sweep("s8", {32'h10, 32'h0, 32'h0, 32'h7}, 4'b0000, -1, -1);

    // Drop enable while channel 1 is presented: sweep completes, then idle.
    sweep("s9", {32'h0, 32'h0, 32'h0, 32'd91}, 4'b0000, -1, 1);
    seen = 0;
    repeat (30) begin
      step();
      if (rec_valid !== 1'b0 || clear_displacement !== 4'b0000) seen++;
    end
    check("idle_quiet", 64'(seen), 64'd0);

    // Re-enable re-runs INIT, so deltas restart from zero.
    enable = 1'b1;
    step();
    check("reinit_clear", 64'(clear_displacement), 64'hF);
    sweep("s10", {32'h20, 32'h3, 32'h0, 32'd100}, 4'b0000, -1, -1);

    // Reset mid-EMIT drops the pending record and clears overrun.
    wait_valid("s11");
    rst_n = 1'b0;
    step();
    check("midrst_valid", 64'(rec_valid), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    check("midrst_delta", 64'(rec_delta), 64'd0);
    rst_n = 1'b1;
    step();
    check("postrst_valid", 64'(rec_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadrature_scheduler.md
QUADRATURE_SCHEDULER -- requirements
Module: quadrature_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_CH, 4: number of quadrature decoder channels served.
- COUNTER_WIDTH, 32: displacement width in bits.
- PERIOD, 1000: sample period in clk cycles, minimum 2*NUM_CH+4.
REQ-002 Ports (name, direction, width, meaning), in this order, SHALL be:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- enable, in, 1: run sampling.
- displacement, in, NUM_CH*COUNTER_WIDTH: per-channel decoder counts; channel i at bits [i*W +: W].
- hw_err, in, NUM_CH: per-channel decoder error.
- clear_displacement, out, NUM_CH: decoder clear pulses.
- rec_valid, out, 1: record valid.
- rec_ready, in, 1: record accept.
- rec_chan, out, $clog2(NUM_CH): record channel index.
- rec_delta, out, COUNTER_WIDTH: displacement change since this channel's previous record.
- rec_err, out, 1: channel error seen since its previous record.
- overrun, out, 1: sticky flag; a tick was dropped.
- rec_timestamp, out, 32: present only under the macro (REQ-019).

Function
REQ-003 FSM states SHALL be IDLE, INIT, WAIT_TICK, CAPTURE and EMIT.
REQ-004 IDLE -> INIT SHALL occur when enable=1.
- INIT SHALL last one cycle.
- During INIT, clear_displacement SHALL be all ones and every last_disp register SHALL load 0.
- INIT SHALL then go to WAIT_TICK.
REQ-005 The period timer SHALL count 0..PERIOD-1 while the FSM is not IDLE, starting at 0 on the cycle after INIT.
- tick SHALL be high when the count equals PERIOD-1.
REQ-006 WAIT_TICK with tick=1 SHALL go to CAPTURE.
REQ-007 CAPTURE SHALL last one cycle and register all NUM_CH displacement values simultaneously into snapshot registers.
- It SHALL then go to EMIT with channel index 0.
REQ-008 In EMIT, rec_valid SHALL be 1 and the record fields SHALL be:
- rec_chan = index.
- rec_delta = snap[index] - last_disp[index], modulo 2^COUNTER_WIDTH (two's-complement wrap, no saturation).
- rec_err = err_sticky[index].
REQ-009 Latency: tick in cycle T -> snapshot registered at end of T+1 -> rec_valid high in cycle T+2.
REQ-010 Handshake rules:
- A record transfers on a cycle with rec_valid=1 and rec_ready=1.
- Record fields SHALL be stable while rec_valid=1 and rec_ready=0.
- rec_valid SHALL NOT drop before transfer.
REQ-011 On transfer:
- last_disp[index] SHALL load snap[index].
- If index < NUM_CH-1, index SHALL increment, giving back-to-back records with no bubble.
- Otherwise the FSM SHALL go to WAIT_TICK.
REQ-012 A tick while in CAPTURE or EMIT SHALL be dropped and SHALL set overrun.
- overrun SHALL clear only on reset.
REQ-013 err_sticky[i] SHALL set on any cycle with hw_err[i]=1.
- It SHALL clear on transfer of channel i's record.
- If hw_err[i]=1 in the transfer cycle, set SHALL win.
REQ-014 enable=0 SHALL be handled as follows:
- In WAIT_TICK: go to IDLE next cycle.
- In CAPTURE or EMIT: finish the current sweep, then go to IDLE instead of WAIT_TICK.
- Re-enabling SHALL re-run INIT.
REQ-015 clear_displacement SHALL be 0 in every state except INIT.

Reset
REQ-016 With rst_n=0 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (clear_displacement, rec_valid, rec_chan, rec_delta, rec_err, overrun, rec_timestamp).
- The timer, index, snapshots, last_disp and err_sticky SHALL also clear.
REQ-017 Reset SHALL take effect mid-sweep, dropping any pending record.

Configuration
REQ-018 Macro QUAD_SCHED_TIMESTAMP_EN SHALL gate the timestamp feature.
REQ-019 With the macro defined:
- A free-running 32-bit cycle counter SHALL run from reset, wrapping at 2^32.
- Its value SHALL be registered in CAPTURE.
- rec_timestamp SHALL carry that value for every record of the sweep.
- Without the macro, neither the port nor the counter SHALL exist.

Structure
REQ-020 Package quad_sched_pkg SHALL hold the FSM state enum and the record struct (chan, delta, err, optional timestamp).
REQ-021 Sub-module quad_sched_timer SHALL implement the period timer (inputs run, clk, rst_n; output tick).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then enable with NUM_CH=4, PERIOD=20 -> one cycle of clear_displacement=4'b1111, and first rec_valid exactly 2 cycles after tick.
- Channel 2 displacement 0 -> 5 -> 3 with rec_ready=1 -> rec_delta 5, then 0xFFFFFFFE, on channel 2.
- last_disp 0xFFFFFFFD and displacement 0x00000002 -> rec_delta 5 (wrap-around).
- rec_ready held 0 for 30 cycles with PERIOD=20 -> fields stable, overrun=1, and no record lost or duplicated.
- hw_err[1] pulsed for one cycle -> rec_err=1 on the next channel-1 record only; hw_err[1] high in its transfer cycle -> rec_err=1 on the following channel-1 record.
- enable dropped during the EMIT of channel 1 -> channels 2 and 3 still emitted, then IDLE; rst_n=0 mid-EMIT -> rec_valid=0 on the next cycle.
